// File: rtl/serial_mult_engine.sv
// Bit-serial A/B loader, shift-and-add (or carry-less XOR) multiplier, serial product unloader.
// Product bit 0 appears DATA_WIDTH edges after the last operand bit; no backpressure, input ignored while busy.
module serial_mult_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(2*DATA_WIDTH)+1
) (
  input  logic clk,
  input  logic resetn,
  input  logic in_valid,
  input  logic in_a,
  input  logic in_b,
  input  logic mode,
  output logic busy,
  output logic out_valid,
  output logic out_mult
);

  localparam int PW = 2*DATA_WIDTH;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_MULT   = 2'd1;
  localparam logic [1:0] ST_UNLOAD = 2'd2;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH-1);
  localparam logic [CNT_WIDTH-1:0] LAST_OUT = CNT_WIDTH'(PW);

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic [PW-1:0]         mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [PW-1:0]         acc;
  logic [PW-1:0]         acc_step;
  logic                  mode_r;

  // mcand holds A shifted left by the current iteration; mplier presents B[i] at bit 0.
  always_comb begin
    acc_step = acc;
    if (mplier[0]) begin
      acc_step = mode_r ? (acc ^ mcand) : (acc + mcand);
    end
  end

  assign busy = (state != ST_LOAD);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_LOAD;
      bit_cnt   <= '0;
      out_cnt   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      mode_r    <= 1'b0;
      out_valid <= 1'b0;
      out_mult  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            // LSB-first bits enter at the top, so after DATA_WIDTH bits A/B sit aligned at bit 0.
            mcand  <= {{DATA_WIDTH{1'b0}}, in_a, mcand[DATA_WIDTH-1:1]};
            mplier <= {in_b, mplier[DATA_WIDTH-1:1]};
            if (bit_cnt == '0) begin
              mode_r <= mode;
            end
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              acc     <= '0;
              state   <= ST_MULT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        ST_MULT: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (bit_cnt == LAST_BIT) begin
            // acc doubles as the output shift register from here on.
            bit_cnt   <= '0;
            acc       <= acc_step >> 1;
            out_mult  <= acc_step[0];
            out_valid <= 1'b1;
            out_cnt   <= CNT_WIDTH'(1);
            state     <= ST_UNLOAD;
          end else begin
            acc     <= acc_step;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_UNLOAD: begin
          if (out_cnt == LAST_OUT) begin
            out_valid <= 1'b0;
            out_mult  <= 1'b0;
            out_cnt   <= '0;
            state     <= ST_LOAD;
          end else begin
            out_mult <= acc[0];
            acc      <= acc >> 1;
            out_cnt  <= out_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mult_engine.sv
// Scoreboard bench for serial_mult_engine at DATA_WIDTH 4, 8 and 32 sharing one serial input set.
module tb_serial_mult_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic in_a = 1'b0;
  logic in_b = 1'b0;
  logic mode = 1'b0;

  logic busy4, ov4, om4, busy8, ov8, om8, busy32, ov32, om32;

  serial_mult_engine #(.DATA_WIDTH(4)) u_w4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .mode(mode),
    .busy(busy4), .out_valid(ov4), .out_mult(om4));

  serial_mult_engine #(.DATA_WIDTH(8)) u_w8 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .mode(mode),
    .busy(busy8), .out_valid(ov8), .out_mult(om8));

  serial_mult_engine #(.DATA_WIDTH(32)) u_w32 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .mode(mode),
    .busy(busy32), .out_valid(ov32), .out_mult(om32));

  int cur_w = 4;
  logic busy_s, ov_s, om_s;
  assign busy_s = (cur_w == 4) ? busy4 : (cur_w == 8) ? busy8 : busy32;
  assign ov_s   = (cur_w == 4) ? ov4   : (cur_w == 8) ? ov8   : ov32;
  assign om_s   = (cur_w == 4) ? om4   : (cur_w == 8) ? om8   : om32;

  typedef struct { logic [63:0] prod; int e0; int w; } exp_t;
  typedef struct { logic [63:0] prod; int nb; int fc; } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit rst_edge = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !resetn;
  end

  logic [63:0] m_prod = '0;
  int m_nb = 0;
  int m_fc = 0;

  // Collects each out_valid burst into one observed product; a reset edge discards a partial burst.
  always @(negedge clk) begin
    if (rst_edge) begin
      m_nb   = 0;
      m_prod = '0;
    end else if (ov_s === 1'b1) begin
      if (m_nb == 0) m_fc = cyc;
      if (m_nb < 64) m_prod[m_nb] = om_s;
      m_nb++;
    end else if (m_nb > 0) begin
      obs_q.push_back('{m_prod, m_nb, m_fc});
      m_nb   = 0;
      m_prod = '0;
    end
  end

  function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) if (b[i]) r = r ^ ({32'b0, a} << i);
    return r;
  endfunction

  task automatic do_reset(input int w);
    cur_w    = w;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_a     = 1'b0;
    in_b     = 1'b0;
    mode     = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
  endtask

  // Drives one frame; returns at the falling edge after the edge that accepted the last bit.
  task automatic send_frame(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                            input int max_gap, input bit push, input logic [63:0] expv);
    for (int i = 0; i < w; i++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        repeat (g) begin
          in_valid = 1'b0;
          in_a = 1'($urandom);
          in_b = 1'($urandom);
          mode = 1'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_a = a[i];
      in_b = b[i];
      mode = (i == 0) ? m : ~m;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_a = 1'b0;
    in_b = 1'b0;
    if (push) exp_q.push_back('{expv, cyc, w});
  endtask

  task automatic get_pair(output obs_t o, output exp_t e, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    o.prod = '0; o.nb = 0; o.fc = 0;
    e.prod = '0; e.e0 = 0; e.w = 0;
    while (obs_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o  = obs_q.pop_front();
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset(4);
    total++; if (busy_s !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_s); else passed++;
    total++; if (ov_s !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", ov_s); else passed++;
    total++; if (om_s !== 1'b0) $display("FAIL reset_out_mult: got %b expected 0", om_s); else passed++;
  endtask

  task automatic test_int_mult();
    obs_t o; exp_t e; bit ok;
    do_reset(4);
    send_frame(4, 32'hB, 32'h6, 1'b0, 0, 1'b1, 64'h42);
    total++; if (busy_s !== 1'b1) $display("FAIL int_busy_after_e0: got %b expected 1", busy_s); else passed++;
    get_pair(o, e, ok);
    total++; if (!ok || o.prod !== e.prod) $display("FAIL int_prod: got %h expected %h ok=%0d", o.prod, e.prod, ok); else passed++;
    total++; if (!ok || o.nb != 2*e.w) $display("FAIL int_len: got %0d expected %0d", o.nb, 2*e.w); else passed++;
    total++; if (!ok || o.fc - e.e0 != e.w) $display("FAIL int_latency: got %0d expected %0d", o.fc - e.e0, e.w); else passed++;
  endtask

  task automatic test_clmul();
    logic [3:0]  ta [3] = '{4'hB, 4'hF, 4'hF};
    logic [3:0]  tb [3] = '{4'h6, 4'hF, 4'hF};
    logic        tm [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] tp [3] = '{64'h3A, 64'h55, 64'hE1};
    obs_t o; exp_t e; bit ok;
    do_reset(4);
    for (int k = 0; k < 3; k++) begin
      send_frame(4, {28'b0, ta[k]}, {28'b0, tb[k]}, tm[k], 0, 1'b1, tp[k]);
      get_pair(o, e, ok);
      total++; if (!ok || o.prod !== e.prod) $display("FAIL clmul_prod[%0d]: got %h expected %h ok=%0d", k, o.prod, e.prod, ok); else passed++;
      total++; if (!ok || o.nb != 2*e.w) $display("FAIL clmul_len[%0d]: got %0d expected %0d", k, o.nb, 2*e.w); else passed++;
    end
  endtask

  task automatic test_stall_w32();
    obs_t o; exp_t e; bit ok;
    do_reset(32);
    send_frame(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 1'b1, 64'hFFFF_FFFE_0000_0001);
    get_pair(o, e, ok);
    total++; if (!ok || o.prod !== e.prod) $display("FAIL stall_prod: got %h expected %h ok=%0d", o.prod, e.prod, ok); else passed++;
    total++; if (!ok || o.nb != 2*e.w) $display("FAIL stall_len: got %0d expected %0d", o.nb, 2*e.w); else passed++;
    total++; if (!ok || o.fc - e.e0 != e.w) $display("FAIL stall_latency: got %0d expected %0d", o.fc - e.e0, e.w); else passed++;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e; bit ok;
    logic [31:0] a1, b1, a2, b2;
    int busy_cnt;
    do_reset(8);
    a1 = 32'($urandom_range(255, 1));
    b1 = 32'($urandom_range(255, 1));
    a2 = 32'($urandom_range(255, 1));
    b2 = 32'($urandom_range(255, 1));
    send_frame(8, a1, b1, 1'b0, 0, 1'b1, {32'b0, a1} * {32'b0, b1});
    busy_cnt = 0;
    while (busy_s === 1'b1 && busy_cnt < 1000) begin
      in_valid = 1'b1;
      in_a = 1'($urandom);
      in_b = 1'($urandom);
      mode = 1'($urandom);
      @(negedge clk);
      busy_cnt++;
    end
    total++; if (busy_cnt != 24) $display("FAIL b2b_busy_cycles: got %0d expected 24", busy_cnt); else passed++;
    send_frame(8, a2, b2, 1'b1, 0, 1'b1, clmul(a2, b2, 8));
    for (int k = 0; k < 2; k++) begin
      get_pair(o, e, ok);
      total++; if (!ok || o.prod !== e.prod) $display("FAIL b2b_prod[%0d]: got %h expected %h ok=%0d", k, o.prod, e.prod, ok); else passed++;
      total++; if (!ok || o.fc - e.e0 != e.w) $display("FAIL b2b_latency[%0d]: got %0d expected %0d", k, o.fc - e.e0, e.w); else passed++;
    end
  endtask

  task automatic test_reset_pulses();
    obs_t o; exp_t e; bit ok;
    do_reset(8);
    for (int s = 0; s < 3; s++) begin
      if (s == 0) begin
        send_frame(2, 32'h3, 32'h3, 1'b0, 0, 1'b0, '0);
        in_valid = 1'b1;
        in_a = 1'b1;
        in_b = 1'b1;
      end else begin
        send_frame(8, 32'hA5, 32'h3C, 1'b1, 0, 1'b0, '0);
        repeat ((s == 1) ? 3 : 12) @(negedge clk);
        if (s == 2) begin
          total++; if (ov_s !== 1'b1) $display("FAIL rstp_in_unload: got out_valid %b expected 1", ov_s); else passed++;
        end
      end
      resetn = 1'b0;
      @(negedge clk);
      resetn   = 1'b1;
      in_valid = 1'b0;
      total++; if (busy_s !== 1'b0) $display("FAIL rstp_busy[%0d]: got %b expected 0", s, busy_s); else passed++;
      total++; if (ov_s !== 1'b0) $display("FAIL rstp_out_valid[%0d]: got %b expected 0", s, ov_s); else passed++;
      total++; if (om_s !== 1'b0) $display("FAIL rstp_out_mult[%0d]: got %b expected 0", s, om_s); else passed++;
    end
    repeat (30) @(negedge clk);
    total++; if (obs_q.size() != 0) $display("FAIL rstp_no_output: got %0d frames expected 0", obs_q.size()); else passed++;
    send_frame(8, 32'h03, 32'h05, 1'b0, 0, 1'b1, 64'h000F);
    get_pair(o, e, ok);
    total++; if (!ok || o.prod !== e.prod) $display("FAIL rstp_clean_prod: got %h expected %h ok=%0d", o.prod, e.prod, ok); else passed++;
    total++; if (!ok || o.nb != 2*e.w) $display("FAIL rstp_clean_len: got %0d expected %0d", o.nb, 2*e.w); else passed++;
  endtask

  task automatic test_zero();
    obs_t o; exp_t e; bit ok;
    do_reset(4);
    for (int m = 0; m < 2; m++) begin
      send_frame(4, 32'h0, 32'h9, 1'(m), 0, 1'b1, 64'h0);
      get_pair(o, e, ok);
      total++; if (!ok || o.prod !== e.prod) $display("FAIL zero_prod[%0d]: got %h expected %h ok=%0d", m, o.prod, e.prod, ok); else passed++;
      total++; if (!ok || o.nb != 2*e.w) $display("FAIL zero_len[%0d]: got %0d expected %0d", m, o.nb, 2*e.w); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_int_mult();
    test_clmul();
    test_stall_w32();
    test_back_to_back();
    test_reset_pulses();
    test_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
